irom_arbiter: RTL and testbench
===============================

Name: irom_arbiter

Overview:
- Shares the single instruction-ROM ready/valid port between two requesters: port 0 (CPU fetch) and port 1 (debug/loader read port).
- Round-robin grant.
- One outstanding ROM transaction at a time, with a watchdog timeout.
- Sits between the requesters and the ROM's `ready`/`addr`/`dout`/`valid` pins inside the CPU top.

Parameters:
- DWIDTH, 16, ROM data width
- AWIDTH, 12, ROM address width
- TIMEOUT, 64, max cycles waiting for mem_valid before aborting (≥2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  port 0 request level; held with addr0 stable until rsp_valid0
- addr0  in  AWIDTH  port 0 address
- rsp_valid0  out  1  port 0 one-cycle response strobe
- rsp_err0  out  1  qualifies rsp_valid0; 1 = timed out
- rsp_data0  out  DWIDTH  port 0 read data
- req1, addr1, rsp_valid1, rsp_err1, rsp_data1: same as port 0, for port 1
- mem_ready  out  1  one-cycle request strobe to ROM
- mem_addr  out  AWIDTH  ROM address, registered
- mem_dout  in  DWIDTH  ROM data
- mem_valid  in  1  ROM response strobe
- busy  out  1  transaction in flight (state != IDLE)
- owner  out  1  index of current/last granted port

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_ready=0; mem_addr=0; owner=1, so port 0 wins the first tie; cnt=0; all rsp_* = 0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req: grant ~owner (round-robin).
  - On grant, at the clock edge: owner <= granted index; mem_addr <= its addr; go to ISSUE.
- ISSUE
  - mem_ready=1 for exactly one cycle; cnt <= 0; go to WAIT.
  - A req-sample edge at cycle N gives mem_ready high during cycle N+1.
- WAIT
  - mem_valid=1: go to IDLE.
    - rsp_valid[owner]=1, rsp_err[owner]=0, rsp_data[owner]=mem_dout. These are combinational, same cycle as mem_valid.
  - Else if cnt==TIMEOUT-1: go to IDLE.
    - rsp_valid[owner]=1, rsp_err[owner]=1, rsp_data[owner]=0.
  - Else cnt <= cnt+1.
- Response outputs
  - The non-owner port's rsp_* is always 0.
  - rsp_data of a port is 0 whenever its rsp_valid is 0.
- Back-to-back: the earliest next grant is decided in the IDLE cycle after completion. Minimum period per transaction is 3 cycles with single-cycle ROM latency.
- mem_valid seen in IDLE or ISSUE is ignored: no response, no state change. A late mem_valid arriving after a timeout is therefore dropped.
- A requester dropping req while its transaction is in flight does not abort it. The response strobe still fires, and the requester ignores it.
- Address changes during ISSUE/WAIT are ignored; mem_addr is latched at grant.
- Width of cnt is clog2(TIMEOUT). It never wraps; the terminal compare precedes the increment.
- Fairness: under continuous req0 & req1, grants strictly alternate 0,1,0,1,...
- Reset asserted mid-transaction: immediate return to reset values. No response is produced for the aborted transaction.

Decomposition:
- Shared package (cpu_pkg): state encoding localparams ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2; port-index constants P_FETCH=0, P_DBG=1.
- One natural sub-module: rr_pick2, a combinational 2-way round-robin picker (inputs req[1:0], last; outputs gnt_valid, gnt_idx).
- Counter and FSM stay in irom_arbiter.

Test Plan:
1. Reset, then req0=1, addr0=12'h010; ROM returns valid 1 cycle after mem_ready with mem_dout=16'hA5A5 -> mem_ready in cycle 2 with mem_addr=12'h010; rsp_valid0=1, rsp_data0=16'hA5A5, rsp_err0=0 in cycle 3; port 1 outputs stay 0.
2. req0 and req1 held high, addr0=12'h001, addr1=12'h002, ROM latency 1 -> mem_addr sequence 001, 002, 001, 002; owner alternates 0,1,0,1; one response every 3 cycles.
3. req1 only, ROM never asserts valid, TIMEOUT=64 -> rsp_valid1=1 and rsp_err1=1, rsp_data1=0 exactly 64 cycles after mem_ready; busy=0 the next cycle. A mem_valid injected 5 cycles later produces no response.
4. Stray mem_valid=1 while in IDLE with no req -> no rsp_valid on either port; state stays IDLE.
5. req0 granted, rst_n pulled low during WAIT for 1 cycle, then ROM valid arrives -> all outputs at reset values; no rsp_valid0; next req0 issues normally.
6. req0 granted; addr0 changed to 12'hFFF and req0 dropped during WAIT -> mem_addr keeps the original address; rsp_valid0 still pulses once on mem_valid.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - FSM state encoding and port-index constants for the instruction-ROM arbiter
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic P_FETCH = 1'b0;
  localparam logic P_DBG   = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational 2-way round-robin picker
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // On a tie the port that did not win last time goes next.
  assign gnt_valid = |req;
  assign gnt_idx   = (&req) ? ~last : req[1];

endmodule

// File: rtl/irom_arbiter.sv
// rtl/irom_arbiter.sv - shares one instruction-ROM ready/valid port between CPU fetch and debug reads
module irom_arbiter
  import cpu_pkg::*;
#(
  parameter int DWIDTH  = 16,
  parameter int AWIDTH  = 12,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [AWIDTH-1:0] addr0,
  output logic              rsp_valid0,
  output logic              rsp_err0,
  output logic [DWIDTH-1:0] rsp_data0,
  input  logic              req1,
  input  logic [AWIDTH-1:0] addr1,
  output logic              rsp_valid1,
  output logic              rsp_err1,
  output logic [DWIDTH-1:0] rsp_data1,
  output logic              mem_ready,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_dout,
  input  logic              mem_valid,
  output logic              busy,
  output logic              owner
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              gnt_valid, gnt_idx;
  logic              done, err;

  rr_pick2 u_pick (
    .req       ({req1, req0}),
    .last      (owner_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= P_DBG;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // mem_valid outside WAIT is deliberately ignored, so late ROM replies are dropped.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_idx;
          addr_d  = (gnt_idx == P_DBG) ? addr1 : addr0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_valid) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          done    = 1'b1;
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_ready = (state_q == ST_ISSUE);
  assign mem_addr  = addr_q;
  assign busy      = (state_q != ST_IDLE);
  assign owner     = owner_q;

  assign rsp_valid0 = done & (owner_q == P_FETCH);
  assign rsp_err0   = rsp_valid0 & err;
  assign rsp_data0  = (rsp_valid0 && !err) ? mem_dout : '0;
  assign rsp_valid1 = done & (owner_q == P_DBG);
  assign rsp_err1   = rsp_valid1 & err;
  assign rsp_data1  = (rsp_valid1 && !err) ? mem_dout : '0;

endmodule

// File: tb/tb_irom_arbiter.sv
// tb/tb_irom_arbiter.sv - directed self-checking bench for irom_arbiter
module tb_irom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, mem_valid;
  logic [11:0] addr0, addr1;
  logic [15:0] mem_dout;
  logic        rsp_valid0, rsp_err0, rsp_valid1, rsp_err1;
  logic [15:0] rsp_data0, rsp_data1;
  logic        mem_ready, busy, owner;
  logic [11:0] mem_addr;

  int checks = 0;
  int errors = 0;

  irom_arbiter #(.DWIDTH(16), .AWIDTH(12), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .addr0      (addr0),
    .rsp_valid0 (rsp_valid0),
    .rsp_err0   (rsp_err0),
    .rsp_data0  (rsp_data0),
    .req1       (req1),
    .addr1      (addr1),
    .rsp_valid1 (rsp_valid1),
    .rsp_err1   (rsp_err1),
    .rsp_data1  (rsp_data1),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .mem_valid  (mem_valid),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    #1;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_owner"}, owner, 1);
    chk({tag, "_ready"}, mem_ready, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_rv"}, {rsp_valid0, rsp_err0, rsp_valid1, rsp_err1}, 0);
    chk({tag, "_rd"}, {rsp_data0, rsp_data1}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req0 = 0; req1 = 0; addr0 = '0; addr1 = '0;
    mem_valid = 0; mem_dout = '0;
    #2;

    // 1: single fetch with 1-cycle ROM latency
    do_reset();
    chk_reset_vals("t1_reset");
    req0 = 1; addr0 = 12'h010;
    #1 chk("t1_idle_ready", mem_ready, 0);
    cyc();
    #1;
    chk("t1_ready", mem_ready, 1);
    chk("t1_addr", mem_addr, 12'h010);
    chk("t1_owner", owner, 0);
    chk("t1_busy", busy, 1);
    cyc();
    mem_valid = 1; mem_dout = 16'hA5A5;
    #1;
    chk("t1_ready_low", mem_ready, 0);
    chk("t1_rv0", {rsp_valid0, rsp_err0}, 2'b10);
    chk("t1_rd0", rsp_data0, 16'hA5A5);
    chk("t1_port1", {rsp_valid1, rsp_err1, rsp_data1}, 0);
    req0 = 0;
    cyc();
    mem_valid = 0;
    #1;
    chk("t1_done_busy", busy, 0);
    chk("t1_done_rv0", rsp_valid0, 0);

    // 2: both ports continuously requesting alternate strictly
    do_reset();
    req0 = 1; req1 = 1; addr0 = 12'h001; addr1 = 12'h002;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t2_idle_busy", busy, 0);
      cyc();
      #1;
      chk("t2_ready", mem_ready, 1);
      chk("t2_addr", mem_addr, (k % 2 == 0) ? 12'h001 : 12'h002);
      chk("t2_owner", owner, k % 2);
      cyc();
      mem_valid = 1; mem_dout = 16'h1000 + 16'(k);
      #1;
      if (k % 2 == 0) begin
        chk("t2_rv0", {rsp_valid0, rsp_valid1}, 2'b10);
        chk("t2_rd0", rsp_data0, 16'h1000 + 16'(k));
        chk("t2_rd1_zero", rsp_data1, 0);
      end else begin
        chk("t2_rv1", {rsp_valid0, rsp_valid1}, 2'b01);
        chk("t2_rd1", rsp_data1, 16'h1000 + 16'(k));
        chk("t2_rd0_zero", rsp_data0, 0);
      end
      cyc();
      mem_valid = 0;
    end

    // 3: port 1 alone, ROM silent -> timeout 64 cycles after mem_ready
    req0 = 0; req1 = 1; addr1 = 12'h0AB; mem_dout = 16'hBEEF;
    cyc();
    #1;
    chk("t3_ready", mem_ready, 1);
    chk("t3_owner", owner, 1);
    chk("t3_addr", mem_addr, 12'h0AB);
    for (int i = 1; i < 64; i++) begin
      cyc();
      #1 chk("t3_no_early_rsp", {rsp_valid0, rsp_valid1, busy}, 3'b001);
    end
    cyc();
    #1;
    chk("t3_timeout_rv1", {rsp_valid1, rsp_err1}, 2'b11);
    chk("t3_timeout_rd1", rsp_data1, 0);
    chk("t3_timeout_port0", {rsp_valid0, rsp_err0, rsp_data0}, 0);
    req1 = 0;
    cyc();
    #1 chk("t3_busy_after", busy, 0);
    for (int i = 0; i < 4; i++) cyc();
    mem_valid = 1;
    #1 chk("t3_late_valid", {rsp_valid0, rsp_valid1, busy}, 0);
    cyc();
    mem_valid = 0;

    // 4: stray mem_valid in IDLE with no request
    mem_valid = 1; mem_dout = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_stray", {rsp_valid0, rsp_valid1, busy, mem_ready}, 0);
      cyc();
    end
    mem_valid = 0;

    // 5: reset mid-WAIT aborts with no response
    req0 = 1; addr0 = 12'h123;
    cyc();
    #1 chk("t5_ready", mem_ready, 1);
    cyc();
    #1 chk("t5_wait_busy", busy, 1);
    rst_n = 0;
    chk_reset_vals("t5_async");
    cyc();
    rst_n = 1; req0 = 0; mem_valid = 1; mem_dout = 16'h7777;
    #1 chk("t5_no_rsp", {rsp_valid0, rsp_valid1, busy}, 0);
    cyc();
    mem_valid = 0; req0 = 1;
    cyc();
    #1;
    chk("t5_reissue_ready", mem_ready, 1);
    chk("t5_reissue_addr", mem_addr, 12'h123);
    chk("t5_reissue_owner", owner, 0);
    cyc();
    mem_valid = 1; mem_dout = 16'h5A5A;
    #1 chk("t5_reissue_rsp", {rsp_valid0, rsp_err0, rsp_data0}, {2'b10, 16'h5A5A});
    req0 = 0;
    cyc();
    mem_valid = 0;

    // 6: address change and req drop while in flight
    req0 = 1; addr0 = 12'h456;
    cyc();
    #1 chk("t6_addr", mem_addr, 12'h456);
    cyc();
    addr0 = 12'hFFF; req0 = 0;
    #1 chk("t6_wait_rv", rsp_valid0, 0);
    cyc();
    #1 chk("t6_addr_hold", {busy, mem_addr}, {1'b1, 12'h456});
    mem_valid = 1; mem_dout = 16'h0F0F;
    #1 chk("t6_rsp", {rsp_valid0, rsp_err0, rsp_data0}, {2'b10, 16'h0F0F});
    cyc();
    mem_valid = 0;
    #1 chk("t6_after", {rsp_valid0, busy}, 0);
    cyc();
    #1 chk("t6_no_regrant", {busy, mem_ready}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
